// File: rtl/snn_pkg.sv
// Package snn_pkg
// Shared types and constants for the binary spike interface: the encoder
// state type, the LFSR feedback tap mask, and the default sample width and
// window length used by spike_rate_encoder and binary_lif_neuron.
package snn_pkg;

    typedef enum logic {
        ENC_IDLE = 1'b0,
        ENC_RUN  = 1'b1
    } enc_state_t;

    // Feedback taps for x^16+x^14+x^13+x^11+1, as a mask over q[15:0]:
    // bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int SNN_W   = 8;
    localparam int SNN_WIN = 32;

endpackage : snn_pkg

// File: rtl/spike_rate_encoder_if.sv
// Interface spike_rate_encoder_if
// Valid/ready sample channel into the spike rate encoder.
//   s_valid  sample valid (source -> encoder)
//   s_ready  encoder can accept a sample (encoder -> source)
//   s_data   W-bit intensity sample (source -> encoder)
// Modports: master = sample source, slave = encoder.
interface spike_rate_encoder_if
    import snn_pkg::*;
#(
    parameter int W = SNN_W
) ();

    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface : spike_rate_encoder_if

// File: rtl/spike_enc_lfsr.sv
// Module spike_enc_lfsr
// 16-bit Fibonacci LFSR for stochastic spike coding.
//   clk  clock, rising edge
//   rst  asynchronous reset, active-high; loads SEED
//   en   advance one step when high, hold otherwise
//   q    current LFSR state
module spike_enc_lfsr
    import snn_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic        fb_d;

    // XOR of the tapped bits is shifted in at the bottom.
    assign fb_d = ^(lfsr_q & LFSR_TAPS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else if (en) begin
            lfsr_q <= {lfsr_q[14:0], fb_d};
        end
    end

    assign q = lfsr_q;

endmodule : spike_enc_lfsr

// File: rtl/spike_rate_encoder.sv
// Module spike_rate_encoder
// Converts a W-bit intensity sample into a 1-bit spike train spread over a
// window of WIN cycles using first-order sigma-delta rate coding.
// Optional feature macro SPIKE_ENC_STOCH_EN: Bernoulli coding from a 16-bit
// LFSR replaces the sigma-delta accumulator.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active-high
//   s_if       sample channel (slave): s_valid, s_ready, s_data[W-1:0]
//   spike      registered spike bit, one window cycle per clock
//   busy       window in progress
//   win_done   high during the last cycle of a window
//   spike_cnt  spikes emitted in the most recently completed window
module spike_rate_encoder
    import snn_pkg::*;
#(
    parameter int          W         = SNN_W,
    parameter int          WIN       = SNN_WIN,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         CW        = $clog2(WIN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    spike_rate_encoder_if.slave  s_if,
    output logic                 spike,
    output logic                 busy,
    output logic                 win_done,
    output logic [CW-1:0]        spike_cnt
);

    localparam int IW = $clog2(WIN);

    if (W < 1 || W > 16) begin : g_bad_w
        $error("spike_rate_encoder: W must be in 1..16");
    end
    if (WIN < 2) begin : g_bad_win
        $error("spike_rate_encoder: WIN must be >= 2");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("spike_rate_encoder: LFSR_SEED must be nonzero");
    end

    enc_state_t   state_q;
    logic [W-1:0] data_q;
    logic [IW-1:0] idx_q;
    logic [CW-1:0] run_cnt_q;
    logic         spike_q;
    logic [CW-1:0] spike_cnt_q;

    logic         win_last;
    logic         accept;
    logic         spike_d;

    assign win_last    = (state_q == ENC_RUN) && (idx_q == IW'(WIN - 1));
    assign s_if.s_ready = (state_q == ENC_IDLE) || win_last;
    assign accept      = s_if.s_valid && s_if.s_ready;

`ifdef SPIKE_ENC_STOCH_EN
    logic [15:0] lfsr_q;

    spike_enc_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (state_q == ENC_RUN),
        .q   (lfsr_q)
    );

    assign spike_d = (lfsr_q[W-1:0] < data_q);
`else
    logic [W-1:0] acc_q;
    logic [W:0]   acc_sum_d;

    // The carry out of the W-bit phase accumulator is the spike: it fires
    // exactly when the running total d*(i+1) crosses a multiple of 2^W.
    assign acc_sum_d = {1'b0, acc_q} + {1'b0, data_q};
    assign spike_d   = acc_sum_d[W];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ENC_IDLE;
`ifndef SPIKE_ENC_STOCH_EN
            acc_q       <= '0;
`endif
            data_q      <= '0;
            idx_q       <= '0;
            run_cnt_q   <= '0;
            spike_q     <= 1'b0;
            spike_cnt_q <= '0;
        end else begin
            // run_cnt holds spikes of cycles 0..WIN-2; the spike still on the
            // output during the last cycle is added here.
            if (win_last) begin
                spike_cnt_q <= run_cnt_q + CW'(spike_q);
            end

            if (accept) begin
                // Preloading acc with the sample is step 1 of the running sum,
                // so cycle 0 never spikes and the window total is floor(WIN*d/2^W).
                state_q   <= ENC_RUN;
                data_q    <= s_if.s_data;
`ifndef SPIKE_ENC_STOCH_EN
                acc_q     <= s_if.s_data;
`endif
                spike_q   <= 1'b0;
                idx_q     <= '0;
                run_cnt_q <= '0;
            end else if (win_last) begin
                state_q <= ENC_IDLE;
                spike_q <= 1'b0;
            end else if (state_q == ENC_RUN) begin
`ifndef SPIKE_ENC_STOCH_EN
                acc_q     <= acc_sum_d[W-1:0];
`endif
                spike_q   <= spike_d;
                run_cnt_q <= run_cnt_q + CW'(spike_q);
                idx_q     <= idx_q + IW'(1);
            end
        end
    end

    assign spike     = spike_q;
    assign busy      = (state_q == ENC_RUN);
    assign win_done  = win_last;
    assign spike_cnt = spike_cnt_q;

endmodule : spike_rate_encoder

// File: tb/tb_spike_rate_encoder.sv
// Testbench tb_spike_rate_encoder
// Directed samples are pushed with their hand-computed spike patterns into a
// scoreboard queue; a negedge monitor rebuilds each window's spike pattern and
// checks it, the window timing and the reported spike count.
// Define SPIKE_ENC_STOCH_EN to exercise the stochastic build.
module tb_spike_rate_encoder;
    import snn_pkg::*;

    localparam int W   = 8;
    localparam int WIN = 32;
    localparam int CW  = $clog2(WIN + 1);

    typedef struct {
        logic [31:0] pat;
        int          lo;
        int          hi;
        bit          exact;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          spike;
    logic          busy;
    logic          win_done;
    logic [CW-1:0] spike_cnt;

    spike_rate_encoder_if #(.W(W)) s_if ();

    spike_rate_encoder #(
        .W   (W),
        .WIN (WIN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_if      (s_if),
        .spike     (spike),
        .busy      (busy),
        .win_done  (win_done),
        .spike_cnt (spike_cnt)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    // Monitor state
    int          m_idx    = 0;
    logic [31:0] m_pat    = '0;
    bit          pend     = 1'b0;
    int          pend_cnt = 0;
    exp_t        m_e;
    int          m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pat, input int lo, input int hi, input bit exact);
        exp_t e;
        e.pat   = pat;
        e.lo    = lo;
        e.hi    = hi;
        e.exact = exact;
        return e;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            m_idx = 0;
            m_pat = '0;
            pend  = 1'b0;
        end else begin
            if (pend) begin
                check("spike_cnt", 32'(spike_cnt), 32'(pend_cnt));
                pend = 1'b0;
            end
            if (busy) begin
                if (m_idx < WIN) m_pat[m_idx] = spike;
                if (m_idx == 0) check("cycle0_spike", 32'(spike), 32'd0);
                check("s_ready_vs_win_done", 32'(s_if.s_ready), 32'(win_done));
                if (win_done) begin
                    check("win_done_cycle", 32'(m_idx), 32'(WIN - 1));
                    m_cnt = $countones(m_pat);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_window actual=window_end required=none");
                    end else begin
                        m_e = exp_q.pop_front();
                        if (m_e.exact) begin
                            check("spike_pattern", m_pat, m_e.pat);
                        end else begin
                            total++;
                            if (m_cnt < m_e.lo || m_cnt > m_e.hi) begin
                                bad++;
                                $display("FAIL spike_range actual=%0d required=%0d..%0d",
                                         m_cnt, m_e.lo, m_e.hi);
                            end
                        end
                        pend     = 1'b1;
                        pend_cnt = m_cnt;
                    end
                    $display("window done: spikes=%0d pattern=%08h", m_cnt, m_pat);
                    m_idx = 0;
                    m_pat = '0;
                end else begin
                    m_idx++;
                end
            end else begin
                check("idle_spike", 32'(spike), 32'd0);
                check("idle_win_done", 32'(win_done), 32'd0);
                check("idle_s_ready", 32'(s_if.s_ready), 32'd1);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL wait_idle actual=busy required=idle");
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || pend) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (exp_q.size() != 0 || pend) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Present a sample, wait for acceptance, queue its expectation.
    task automatic send(input logic [W-1:0] d, input exp_t e, input bit keep);
        int n = 0;
        @(negedge clk);
        s_if.s_valid = 1'b1;
        s_if.s_data  = d;
        while (!s_if.s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_if.s_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout actual=s_ready_low required=high");
            s_if.s_valid = 1'b0;
        end else begin
            @(posedge clk);
            exp_q.push_back(e);
            $display("sample accepted: d=%0d", d);
            #1;
            if (!keep) s_if.s_valid = 1'b0;
        end
    endtask

    initial begin
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        repeat (2) @(negedge clk);
        check("rst_spike", 32'(spike), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_win_done", 32'(win_done), 32'd0);
        check("rst_s_ready", 32'(s_if.s_ready), 32'd1);
        check("rst_spike_cnt", 32'(spike_cnt), 32'd0);
        #1 rst = 1'b0;

`ifndef SPIKE_ENC_STOCH_EN
        send(8'd0,   mk(32'h0000_0000, 0, 0, 1'b1), 1'b0);  drain();
        send(8'd128, mk(32'hAAAA_AAAA, 0, 0, 1'b1), 1'b0);  drain();
        send(8'd64,  mk(32'h8888_8888, 0, 0, 1'b1), 1'b0);  drain();
        send(8'd255, mk(32'hFFFF_FFFE, 0, 0, 1'b1), 1'b0);  drain();

        // Back-to-back: s_valid held, second sample taken at end of window 1.
        wait_idle();
        send(8'd64, mk(32'h8888_8888, 0, 0, 1'b1), 1'b1);
        s_if.s_data = 8'd192;
        exp_q.push_back(mk(32'hEEEE_EEEE, 0, 0, 1'b1));
        for (int i = 0; i < 2 * WIN - 1; i++) begin
            @(negedge clk);
            check("b2b_busy", 32'(busy), 32'd1);
            if (i == WIN) begin
                s_if.s_valid = 1'b0;
                check("b2b_first_cnt", 32'(spike_cnt), 32'd8);
            end
        end
        drain();
        check("b2b_second_cnt", 32'(spike_cnt), 32'd24);

        // Reset in the middle of a window.
        wait_idle();
        send(8'd128, mk(32'hAAAA_AAAA, 0, 0, 1'b1), 1'b0);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2;
        exp_q.delete();
        rst = 1'b1;
        #1;
        check("midrst_spike", 32'(spike), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_s_ready", 32'(s_if.s_ready), 32'd1);
        check("midrst_spike_cnt", 32'(spike_cnt), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        send(8'd128, mk(32'hAAAA_AAAA, 0, 0, 1'b1), 1'b0);  drain();
        check("post_rst_cnt", 32'(spike_cnt), 32'd16);
`else
        send(8'd0,   mk(32'h0000_0000, 0, 0, 1'b1), 1'b0);  drain();
        check("stoch_zero_cnt", 32'(spike_cnt), 32'd0);
        send(8'd128, mk(32'h0, 8, 24, 1'b0), 1'b0);         drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_spike_rate_encoder
